// File: rtl/nearest_hit_select.sv
`default_nettype none
// ============================================================================
// Module      : nearest_hit_select
// Description : Per-ray nearest-hit reduction. Consumes a stream of
//               (t, hit, triangle id) beats from the divider, keeps the
//               smallest t that passed the hit test and lies strictly above
//               T_MIN, and presents one result per ray (closed by last_in).
//               The result is held until the downstream accepts it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      : sole clock, rising edge
//   reset      : asynchronous, active-high
//   valid_in   : input beat valid (divider quotient valid)
//   in_ready   : high while accumulating; beat taken on valid_in && in_ready
//   t_in       : signed hit distance of the beat
//   hit_in     : geometric hit test passed for this beat
//   tri_id_in  : triangle index of the beat
//   last_in    : final triangle of the current ray
//   valid_out  : per-ray result valid
//   out_ready  : downstream takes the result on valid_out && out_ready
//   hit_found  : at least one qualifying candidate seen
//   t_out      : nearest qualifying t (max positive if none)
//   tri_id_out : index of the nearest triangle (0 if none)
//   beat_count : beats accepted for this ray, saturating at all-ones
// ============================================================================
module nearest_hit_select #(
    parameter int DATA_WIDTH     = 32,
    parameter int QUANTIZED_BITS = 10,
    parameter int ID_WIDTH       = 16,
    parameter int T_MIN          = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         valid_in,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] t_in,
    input  logic                         hit_in,
    input  logic [ID_WIDTH-1:0]          tri_id_in,
    input  logic                         last_in,
    output logic                         valid_out,
    input  logic                         out_ready,
    output logic                         hit_found,
    output logic signed [DATA_WIDTH-1:0] t_out,
    output logic [ID_WIDTH-1:0]          tri_id_out,
    output logic [ID_WIDTH-1:0]          beat_count
);

    // Fractional bits only document the fixed-point format; the compare works
    // on raw values, so the only thing to guard is a nonsensical format.
    if (QUANTIZED_BITS < 0 || QUANTIZED_BITS >= DATA_WIDTH) begin : g_frac_check
        $error("nearest_hit_select: QUANTIZED_BITS must be in [0, DATA_WIDTH-1]");
    end

    localparam logic signed [DATA_WIDTH-1:0] c_t_min   = DATA_WIDTH'(T_MIN);
    // "No hit" sentinel: largest positive value, so any real candidate wins.
    localparam logic signed [DATA_WIDTH-1:0] c_t_empty = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ID_WIDTH-1:0]          c_cnt_max = {ID_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           r_hit_found;
    logic                           w_hit_found_next;
    logic signed [DATA_WIDTH-1:0]   r_best_t;
    logic signed [DATA_WIDTH-1:0]   w_best_t_next;
    logic [ID_WIDTH-1:0]            r_best_id;
    logic [ID_WIDTH-1:0]            w_best_id_next;
    logic [ID_WIDTH-1:0]            r_beat_count;
    logic [ID_WIDTH-1:0]            w_beat_count_next;

    logic                           w_qualify;
    logic                           w_better;

    // Strict compares on both sides: t must clear T_MIN, and an equal t does
    // not displace the earlier triangle.
    assign w_qualify = hit_in && (t_in > c_t_min);
    assign w_better  = w_qualify && (!r_hit_found || (t_in < r_best_t));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_ACCUM;
            r_hit_found  <= 1'b0;
            r_best_t     <= c_t_empty;
            r_best_id    <= '0;
            r_beat_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_hit_found  <= w_hit_found_next;
            r_best_t     <= w_best_t_next;
            r_best_id    <= w_best_id_next;
            r_beat_count <= w_beat_count_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_hit_found_next  = r_hit_found;
        w_best_t_next     = r_best_t;
        w_best_id_next    = r_best_id;
        w_beat_count_next = r_beat_count;

        case (r_state)
            ST_ACCUM: begin
                if (valid_in) begin
                    if (r_beat_count != c_cnt_max) begin
                        w_beat_count_next = r_beat_count + ID_WIDTH'(1);
                    end
                    if (w_better) begin
                        w_hit_found_next = 1'b1;
                        w_best_t_next    = t_in;
                        w_best_id_next   = tri_id_in;
                    end
                    // The last beat is folded in on the same edge that
                    // closes the ray.
                    if (last_in) begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_next      = ST_ACCUM;
                    w_hit_found_next  = 1'b0;
                    w_best_t_next     = c_t_empty;
                    w_best_id_next    = '0;
                    w_beat_count_next = '0;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    assign in_ready   = (r_state == ST_ACCUM);
    assign valid_out  = (r_state == ST_HOLD);
    assign hit_found  = r_hit_found;
    assign t_out      = r_best_t;
    assign tri_id_out = r_best_id;
    assign beat_count = r_beat_count;

endmodule
`default_nettype wire

// File: tb/tb_nearest_hit_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_nearest_hit_select
// Description : Directed bench for nearest_hit_select. Stimulus pushes the
//               hand-computed per-ray result into a queue; a monitor pops
//               and compares whenever a result is handed off downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nearest_hit_select;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam logic [DW-1:0] c_tmax = 32'h7FFF_FFFF;

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] t;
        logic [IW-1:0] id;
        logic [IW-1:0] cnt;
    } exp_t;

    logic                  clock;
    logic                  reset;
    logic                  valid_in;
    logic                  in_ready;
    logic signed [DW-1:0]  t_in;
    logic                  hit_in;
    logic [IW-1:0]         tri_id_in;
    logic                  last_in;
    logic                  valid_out;
    logic                  out_ready;
    logic                  hit_found;
    logic signed [DW-1:0]  t_out;
    logic [IW-1:0]         tri_id_out;
    logic [IW-1:0]         beat_count;

    int   total;
    int   bad;
    exp_t sb[$];

    nearest_hit_select #(
        .DATA_WIDTH    (DW),
        .QUANTIZED_BITS(10),
        .ID_WIDTH      (IW),
        .T_MIN         (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .t_in      (t_in),
        .hit_in    (hit_in),
        .tri_id_in (tri_id_in),
        .last_in   (last_in),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .hit_found (hit_found),
        .t_out     (t_out),
        .tri_id_out(tri_id_out),
        .beat_count(beat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one result per downstream handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && valid_out && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(valid_out), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("hit_found", 64'(hit_found), 64'(e.hit));
                    chk("t_out", 64'(t_out), 64'(e.t));
                    chk("tri_id_out", 64'(tri_id_out), 64'(e.id));
                    chk("beat_count", 64'(beat_count), 64'(e.cnt));
                end
            end
        end
    end

    // Present a beat and wait until the edge that takes it.
    task automatic send_beat(input int t, input logic hit, input int id, input logic last);
        logic rdy;
        int   n;
        valid_in  = 1'b1;
        t_in      = DW'(t);
        hit_in    = hit;
        tri_id_in = IW'(id);
        last_in   = last;
        n = 0;
        do begin
            rdy = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("beat_accept_timeout", 64'(rdy), 64'(1));
    endtask

    task automatic idle(input int cycles);
        valid_in = 1'b0;
        last_in  = 1'b0;
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_valid_out"}, 64'(valid_out), 64'(0));
        chk({tag, "_hit_found"}, 64'(hit_found), 64'(0));
        chk({tag, "_t_out"}, 64'(t_out), 64'(c_tmax));
        chk({tag, "_tri_id_out"}, 64'(tri_id_out), 64'(0));
        chk({tag, "_beat_count"}, 64'(beat_count), 64'(0));
    endtask

    initial begin
        int n;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        valid_in  = 1'b0;
        t_in      = '0;
        hit_in    = 1'b0;
        tri_id_in = '0;
        last_in   = 1'b0;
        out_ready = 1'b1;

        #2;
        chk_reset_values("rst0");
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);

        // Nearest of three hits.
        sb.push_back('{hit: 1'b1, t: 32'd5120, id: 16'd7, cnt: 16'd3});
        send_beat(19865, 1'b1, 3, 1'b0);
        send_beat(5120,  1'b1, 7, 1'b0);
        send_beat(10240, 1'b1, 9, 1'b1);
        valid_in = 1'b0;
        chk("valid_one_cycle_after_last", 64'(valid_out), 64'(1));
        idle(2);

        // No qualifying candidate: miss, t at threshold-below, negative t.
        sb.push_back('{hit: 1'b0, t: c_tmax, id: 16'd0, cnt: 16'd3});
        send_beat(2048, 1'b0, 1, 1'b0);
        send_beat(0,    1'b1, 2, 1'b0);
        send_beat(-500, 1'b1, 3, 1'b1);
        idle(2);

        // Tie keeps the earlier triangle.
        sb.push_back('{hit: 1'b1, t: 32'd4096, id: 16'd4, cnt: 16'd2});
        send_beat(4096, 1'b1, 4, 1'b0);
        send_beat(4096, 1'b1, 5, 1'b1);
        idle(2);

        // Backpressure: result held while upstream keeps a beat pending.
        out_ready = 1'b0;
        sb.push_back('{hit: 1'b1, t: 32'd1000, id: 16'd11, cnt: 16'd1});
        send_beat(1000, 1'b1, 11, 1'b1);
        valid_in  = 1'b1;
        t_in      = 32'sd50;
        hit_in    = 1'b1;
        tri_id_in = 16'd12;
        last_in   = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_valid_out", 64'(valid_out), 64'(1));
            chk("hold_t_out", 64'(t_out), 64'(1000));
            chk("hold_tri_id", 64'(tri_id_out), 64'(11));
            chk("hold_beat_count", 64'(beat_count), 64'(1));
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        sb.push_back('{hit: 1'b1, t: 32'd50, id: 16'd12, cnt: 16'd1});
        send_beat(50, 1'b1, 12, 1'b1);
        idle(2);

        // Reset between edges mid-ray discards the partial result.
        send_beat(700, 1'b1, 1, 1'b0);
        send_beat(800, 1'b1, 2, 1'b0);
        valid_in = 1'b0;
        chk("midray_count", 64'(beat_count), 64'(2));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("rst_mid");
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.push_back('{hit: 1'b1, t: 32'd300, id: 16'd2, cnt: 16'd1});
        send_beat(300, 1'b1, 2, 1'b1);
        idle(2);

        // Threshold is strict: t == T_MIN misses, T_MIN+1 hits.
        sb.push_back('{hit: 1'b0, t: c_tmax, id: 16'd0, cnt: 16'd1});
        send_beat(1, 1'b1, 6, 1'b1);
        idle(2);
        sb.push_back('{hit: 1'b1, t: 32'd2, id: 16'd8, cnt: 16'd1});
        send_beat(2, 1'b1, 8, 1'b1);
        idle(2);

        // Idle cycles with garbage inputs must not count.
        t_in    = 32'sd3;
        hit_in  = 1'b1;
        last_in = 1'b1;
        valid_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_no_count", 64'(beat_count), 64'(0));
        chk("idle_no_hold", 64'(valid_out), 64'(0));

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
